// File: rtl/jtpopeye_frac_cen.sv
// Fractional clock-enable generator: after the PLL has been locked for LOCK_WAIT
// cycles, each channel emits cen pulses at an average rate of clk*n/m.
module jtpopeye_frac_cen #(
  parameter int CHANNELS  = 2,
  parameter int W         = 10,
  parameter int LOCK_WAIT = 1024,
  parameter int DEF_N     = 1,
  parameter int DEF_M     = 2
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           pll_locked,
  input  logic                                           cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [W-1:0]                                   cfg_n,
  input  logic [W-1:0]                                   cfg_m,
  output logic [CHANNELS-1:0]                            cen,
  output logic                                           ready
);

  localparam int                CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int                CW       = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT + 1) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(LOCK_WAIT - 1);
  localparam logic [CHW:0]      CH_LIM   = (CHW + 1)'(CHANNELS);
  localparam logic [W-1:0]      RST_N    = W'(DEF_N);
  localparam logic [W-1:0]      RST_M    = W'(DEF_M);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  lock_s1_q, lock_s1_d;
  logic                  lock_s2_q, lock_s2_d;
  logic                  ready_q, ready_d;
  logic                  run_d;
  logic                  cfg_hit;

  logic [CHANNELS-1:0]   cen_q, cen_d;
  logic [CHANNELS-1:0]   pend_q, pend_d;
  logic [W-1:0]          acc_q   [CHANNELS];
  logic [W-1:0]          acc_d   [CHANNELS];
  logic [W-1:0]          n_act_q [CHANNELS];
  logic [W-1:0]          n_act_d [CHANNELS];
  logic [W-1:0]          m_act_q [CHANNELS];
  logic [W-1:0]          m_act_d [CHANNELS];
  logic [W-1:0]          n_sh_q  [CHANNELS];
  logic [W-1:0]          n_sh_d  [CHANNELS];
  logic [W-1:0]          m_sh_q  [CHANNELS];
  logic [W-1:0]          m_sh_d  [CHANNELS];

  always_comb begin
    lock_s1_d = pll_locked;
    lock_s2_d = lock_s1_q;
  end

  // Lock supervisor: synced lock must hold for LOCK_WAIT settle cycles before RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s2_q) state_d = SETTLE;
      end
      SETTLE: begin
        if (!lock_s2_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s2_q) state_d = WAIT_LOCK;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // cen/acc are computed for the state being entered so that cen is only ever
  // visible while ready is high.
  always_comb begin
    run_d   = (state_d == RUN);
    ready_d = run_d;
    cfg_hit = cfg_we && ({1'b0, cfg_ch} < CH_LIM);
  end

  always_comb begin
    logic [W:0] sum;
    logic       apply;
    sum     = '0;
    apply   = 1'b0;
    cen_d   = '0;
    pend_d  = pend_q;
    acc_d   = acc_q;
    n_act_d = n_act_q;
    m_act_d = m_act_q;
    n_sh_d  = n_sh_q;
    m_sh_d  = m_sh_q;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      acc_d[ch] = '0;
      sum       = {1'b0, acc_q[ch]} + {1'b0, n_act_q[ch]};
      if (run_d && (m_act_q[ch] != '0)) begin
        if (n_act_q[ch] >= m_act_q[ch]) begin
          // Rate saturates at one pulse per cycle; keep acc pinned to avoid growth.
          cen_d[ch] = 1'b1;
        end else if (sum >= {1'b0, m_act_q[ch]}) begin
          cen_d[ch] = 1'b1;
          acc_d[ch] = W'(sum - {1'b0, m_act_q[ch]});
        end else begin
          acc_d[ch] = sum[W-1:0];
        end
      end
      // Ratio swaps land on a pulse boundary so the period in flight is not torn.
      apply = pend_q[ch] && (!run_d || (m_act_q[ch] == '0) || cen_d[ch]);
      if (apply) begin
        n_act_d[ch] = n_sh_q[ch];
        m_act_d[ch] = m_sh_q[ch];
        pend_d[ch]  = 1'b0;
      end
      if (cfg_hit && (cfg_ch == CHW'(ch))) begin
        n_sh_d[ch] = cfg_n;
        m_sh_d[ch] = cfg_m;
        pend_d[ch] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
      ready_q   <= 1'b0;
      cen_q     <= '0;
      pend_q    <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        acc_q[ch]   <= '0;
        n_act_q[ch] <= RST_N;
        m_act_q[ch] <= RST_M;
        n_sh_q[ch]  <= RST_N;
        m_sh_q[ch]  <= RST_M;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lock_s1_q <= lock_s1_d;
      lock_s2_q <= lock_s2_d;
      ready_q   <= ready_d;
      cen_q     <= cen_d;
      pend_q    <= pend_d;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        acc_q[ch]   <= acc_d[ch];
        n_act_q[ch] <= n_act_d[ch];
        m_act_q[ch] <= m_act_d[ch];
        n_sh_q[ch]  <= n_sh_d[ch];
        m_sh_q[ch]  <= m_sh_d[ch];
      end
    end
  end

  assign cen   = cen_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_jtpopeye_frac_cen.sv
// Randomised bench for jtpopeye_frac_cen against a rate/lock-streak reference model.
module tb_jtpopeye_frac_cen;

  localparam int CH        = 3;
  localparam int W         = 10;
  localparam int LOCK_WAIT = 4;

  logic          clk;
  logic          rst_n;
  logic          pll_locked;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [W-1:0]  cfg_n;
  logic [W-1:0]  cfg_m;
  logic [CH-1:0] cen;
  logic          ready;

  int ntests = 0;
  int nfail  = 0;

  // reference model state
  int       lk1, lk2, streak, rc;
  bit       m_run;
  logic [CH-1:0] m_cen;
  int       an[CH], am[CH], sn[CH], sm[CH], acc[CH];
  bit       pend[CH];

  jtpopeye_frac_cen #(
    .CHANNELS(CH), .W(W), .LOCK_WAIT(LOCK_WAIT), .DEF_N(1), .DEF_M(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_n(cfg_n), .cfg_m(cfg_m),
    .cen(cen), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    lk1 = 0; lk2 = 0; streak = 0; rc = 0; m_run = 0; m_cen = '0;
    for (int c = 0; c < CH; c++) begin
      an[c] = 1; am[c] = 2; sn[c] = 1; sm[c] = 2; acc[c] = 0; pend[c] = 0;
    end
  endtask

  // RUN holds exactly when the synchronised lock has been seen high on the
  // last LOCK_WAIT+1 edges; each channel then counts n per cycle modulo m.
  task automatic model_edge();
    int l;
    if (!rst_n) begin
      model_reset();
      return;
    end
    l = lk2; lk2 = lk1; lk1 = int'(pll_locked);
    streak = (l != 0) ? ((streak < 1000) ? streak + 1 : streak) : 0;
    m_run  = (streak >= LOCK_WAIT + 1);
    for (int c = 0; c < CH; c++) begin
      bit fire;
      bit take;
      fire = 0;
      if (m_run && am[c] != 0) begin
        if (an[c] >= am[c]) begin
          fire = 1; acc[c] = 0;
        end else if (acc[c] + an[c] >= am[c]) begin
          fire = 1; acc[c] = acc[c] + an[c] - am[c];
        end else begin
          acc[c] = acc[c] + an[c];
        end
      end else begin
        acc[c] = 0;
      end
      m_cen[c] = fire;
      take = pend[c] && (!m_run || am[c] == 0 || fire);
      if (take) begin
        an[c] = sn[c]; am[c] = sm[c]; pend[c] = 0;
      end
      if (cfg_we && int'(cfg_ch) == c) begin
        sn[c] = int'(cfg_n); sm[c] = int'(cfg_m); pend[c] = 1;
      end
    end
    rc = m_run ? rc + 1 : 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("ready_vs_model", int'(ready), int'(m_run));
    chk("cen_vs_model", int'(cen), int'(m_cen));
    cfg_we = 1'b0;
  endtask

  task automatic write_cfg(input int ch, input int n, input int m);
    cfg_we = 1'b1;
    cfg_ch = 2'(ch);
    cfg_n  = W'(n);
    cfg_m  = W'(m);
  endtask

  task automatic wait_ready(input int bound, output int lat);
    lat = -1;
    for (int k = 1; k <= bound; k++) begin
      step();
      if (ready === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // masks of cen per channel over run cycles 1..len (cycle 1 = current sample)
  task automatic collect(input int len, output int k0, output int k1, output int k2);
    k0 = 0; k1 = 0; k2 = 0;
    for (int t = 1; t <= len; t++) begin
      if (t > 1) step();
      if (cen[0]) k0 |= (1 << t);
      if (cen[1]) k1 |= (1 << t);
      if (cen[2]) k2 |= (1 << t);
    end
  endtask

  task automatic count_pulses(input int len, output int p0, output int p1, output int p2);
    p0 = 0; p1 = 0; p2 = 0;
    for (int t = 0; t < len; t++) begin
      step();
      p0 += int'(cen[0]); p1 += int'(cen[1]); p2 += int'(cen[2]);
    end
  endtask

  initial begin
    int c0, c1, c2, dev, lat, pmask, k0, k1, k2, p0, p1, p2;
    rst_n = 1'b0; pll_locked = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_n = '0; cfg_m = '0;
    model_reset();
    #1;
    chk("reset_ready", int'(ready), 0);
    chk("reset_cen", int'(cen), 0);
    step(); step();
    rst_n = 1'b1;

    // lock-up timing with ratios configured during WAIT_LOCK/SETTLE
    pll_locked = 1'b1;
    write_cfg(0, 1, 3); step();
    write_cfg(1, 5, 7); step();
    for (int e = 3; e <= 6; e++) step();
    chk("ready_before_settle_done", int'(ready), 0);
    chk("cen_before_run", int'(cen), 0);
    step();
    chk("ready_at_cycle7", int'(ready), 1);

    c0 = 0; c1 = 0; c2 = 0; dev = 0;
    for (int t = 1; t <= 300; t++) begin
      if (t > 1) step();
      c0 += int'(cen[0]); c1 += int'(cen[1]); c2 += int'(cen[2]);
      if (t <= 3) chk("ch0_first_pulse_pos", int'(cen[0]), (t == 3) ? 1 : 0);
      if (c1 - (t * 5) / 7 > 1 || (t * 5) / 7 - c1 > 1) dev++;
    end
    chk("ch0_pulses_300", c0, 100);
    chk("ch1_deviation_cycles", dev, 0);
    chk("ch1_pulses_300_in_band", int'(c1 >= 213 && c1 <= 215), 1);
    chk("ch2_default_pulses_300", c2, 150);

    // ratio change mid-period: old 3-spacing until next pulse, then 4
    write_cfg(0, 1, 4);
    pmask = 0;
    for (int t = 301; t <= 315; t++) begin
      step();
      if (cen[0]) pmask |= (1 << (t - 300));
    end
    chk("ch0_respace_mask", pmask, 32'h8888);

    // lock loss and relock
    pll_locked = 1'b0;
    step(); step(); step();
    chk("lockloss_ready", int'(ready), 0);
    chk("lockloss_cen", int'(cen), 0);
    pll_locked = 1'b1;
    wait_ready(30, lat);
    chk("relock_latency", lat, 7);
    collect(8, k0, k1, k2);
    chk("relock_ch0_mask", k0, 32'h110);
    chk("relock_ch1_mask", k1, 32'hEC);

    // edge cases
    write_cfg(3, 0, 0);
    count_pulses(28, p0, p1, p2);
    chk("badch_ch0_pulses", p0, 7);
    chk("badch_ch1_pulses", p1, 20);
    chk("badch_ch2_pulses", p2, 14);
    write_cfg(2, 3, 0);
    count_pulses(4, p0, p1, p2);
    count_pulses(40, p0, p1, p2);
    chk("m0_ch2_pulses", p2, 0);
    chk("m0_ch0_pulses", p0, 10);
    write_cfg(1, 9, 9);
    count_pulses(3, p0, p1, p2);
    count_pulses(20, p0, p1, p2);
    chk("n_eq_m_ch1_pulses", p1, 20);
    write_cfg(2, 1, 1);
    count_pulses(2, p0, p1, p2);
    count_pulses(10, p0, p1, p2);
    chk("from_m0_ch2_pulses", p2, 10);

    // randomised traffic with occasional lock loss
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 7) == 0)
          write_cfg($urandom_range(0, 3), $urandom_range(0, 1023), $urandom_range(0, 1023));
        else
          write_cfg($urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 12));
      end
      if (pll_locked && $urandom_range(0, 149) == 0) pll_locked = 1'b0;
      else if (!pll_locked && $urandom_range(0, 5) == 0) pll_locked = 1'b1;
      step();
    end

    // asynchronous reset mid-RUN restores default ratios
    pll_locked = 1'b1;
    wait_ready(40, lat);
    chk("reached_run_before_reset", int'(lat != -1), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_ready", int'(ready), 0);
    chk("async_reset_cen", int'(cen), 0);
    model_reset();
    #2;
    rst_n = 1'b1;
    wait_ready(30, lat);
    chk("post_reset_latency", lat, 7);
    collect(6, k0, k1, k2);
    chk("post_reset_ch0_mask", k0, 32'h54);
    chk("post_reset_ch1_mask", k1, 32'h54);
    chk("post_reset_ch2_mask", k2, 32'h54);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
